// File: rtl/plic_target_core_if.sv
// Gateway, config-write, claim/complete and eip bundle between a PLIC target and its users.
// slave = target core, master = gateways/hart/register block.
interface plic_target_core_if #(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3,
  parameter int ID_W    = $clog2(NUM_SRC + 1)
);
  logic [NUM_SRC-1:0] gw_valid;
  logic [NUM_SRC-1:0] gw_ready;
  logic [NUM_SRC-1:0] gw_complete;

  logic               prio_we;
  logic [ID_W-1:0]    prio_id;
  logic [PRIO_W-1:0]  prio_wdata;
  logic               en_we;
  logic [NUM_SRC-1:0] en_wdata;
  logic               thr_we;
  logic [PRIO_W-1:0]  thr_wdata;

  logic               claim_req;
  logic               claim_rsp_valid;
  logic [ID_W-1:0]    claim_rsp_id;
  logic               complete_req;
  logic [ID_W-1:0]    complete_id;

  logic               eip;

  modport slave (
    input  gw_valid, prio_we, prio_id, prio_wdata, en_we, en_wdata,
           thr_we, thr_wdata, claim_req, complete_req, complete_id,
    output gw_ready, gw_complete, claim_rsp_valid, claim_rsp_id, eip
  );

  modport master (
    output gw_valid, prio_we, prio_id, prio_wdata, en_we, en_wdata,
           thr_we, thr_wdata, claim_req, complete_req, complete_id,
    input  gw_ready, gw_complete, claim_rsp_valid, claim_rsp_id, eip
  );
endinterface

// File: rtl/plic_target_core.sv
// Single-context PLIC target: pending bits, priority arbitration, claim/complete, registered eip.
// Claim response and eip are one cycle after the causing edge; gateways stall while their source is pending.
module plic_target_core #(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3,
  parameter int ID_W    = $clog2(NUM_SRC + 1)
) (
  input  logic              clock,
  input  logic              reset,
  plic_target_core_if.slave bus
);

  logic [NUM_SRC-1:0]             pending_q, pending_d;
  logic [NUM_SRC-1:0][PRIO_W-1:0] prio_q, prio_d;
  logic [NUM_SRC-1:0]             en_q, en_d;
  logic [PRIO_W-1:0]              thr_q, thr_d;
  logic                           eip_q, eip_d;
  logic [NUM_SRC-1:0]             gw_complete_q, gw_complete_d;
  logic                           claim_rsp_valid_q, claim_rsp_valid_d;
  logic [ID_W-1:0]                claim_rsp_id_q, claim_rsp_id_d;

  logic [ID_W-1:0]                best_id;
  logic [PRIO_W-1:0]              best_prio;

  // Strict '>' while scanning upward keeps the lowest ID on priority ties.
  always_comb begin
    best_id   = '0;
    best_prio = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pending_q[i] && en_q[i] && (prio_q[i] != '0) && (prio_q[i] > best_prio)) begin
        best_prio = prio_q[i];
        best_id   = ID_W'(i + 1);
      end
    end
  end

  always_comb begin
    pending_d         = pending_q | (bus.gw_valid & ~pending_q);
    prio_d            = prio_q;
    en_d              = en_q;
    thr_d             = thr_q;
    eip_d             = (best_prio > thr_q);
    gw_complete_d     = '0;
    claim_rsp_valid_d = bus.claim_req;
    claim_rsp_id_d    = bus.claim_req ? best_id : '0;

    for (int i = 0; i < NUM_SRC; i++) begin
      // A claimed source is already pending, so it cannot be re-accepted on this same edge.
      if (bus.claim_req && (best_id == ID_W'(i + 1))) begin
        pending_d[i] = 1'b0;
      end
      if (bus.prio_we && (bus.prio_id == ID_W'(i + 1))) begin
        prio_d[i] = bus.prio_wdata;
      end
      if (bus.complete_req && (bus.complete_id == ID_W'(i + 1)) && en_q[i]) begin
        gw_complete_d[i] = 1'b1;
      end
    end

    if (bus.en_we) begin
      en_d = bus.en_wdata;
    end
    if (bus.thr_we) begin
      thr_d = bus.thr_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q         <= '0;
      prio_q            <= '0;
      en_q              <= '0;
      thr_q             <= '0;
      eip_q             <= 1'b0;
      gw_complete_q     <= '0;
      claim_rsp_valid_q <= 1'b0;
      claim_rsp_id_q    <= '0;
    end else begin
      pending_q         <= pending_d;
      prio_q            <= prio_d;
      en_q              <= en_d;
      thr_q             <= thr_d;
      eip_q             <= eip_d;
      gw_complete_q     <= gw_complete_d;
      claim_rsp_valid_q <= claim_rsp_valid_d;
      claim_rsp_id_q    <= claim_rsp_id_d;
    end
  end

  assign bus.gw_ready        = ~pending_q;
  assign bus.gw_complete     = gw_complete_q;
  assign bus.claim_rsp_valid = claim_rsp_valid_q;
  assign bus.claim_rsp_id    = claim_rsp_id_q;
  assign bus.eip             = eip_q;

endmodule
